// File: rtl/conv3x3_engine.sv
// 3x3 binary-image convolution stage: snapshots an 8x8 bit image and streams
// 36 ReLU-saturated window sums in raster order over a valid/ready handshake.
module conv3x3_engine #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int ACC_WIDTH     = DATAWIDTH_BUS + 4
) (
  input  logic                     CONV_CLOCK_50,
  input  logic                     CONV_RESET_InLow,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row00_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row01_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row02_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row03_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row04_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row05_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row06_DataInBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_Row07_DataInBUS,
  input  logic                     CONV_Start_InHigh,
  input  logic [3:0]               CONV_WeightAddress_InBUS,
  input  logic [DATAWIDTH_BUS-1:0] CONV_New_WeightInBUS,
  input  logic                     CONV_LoadWeight_InLow,
  input  logic                     CONV_Ready_InHigh,
  output logic                     CONV_Valid_OutHigh,
  output logic [DATAWIDTH_BUS-1:0] CONV_Result_DataOutBUS,
  output logic [5:0]               CONV_ResultIndex_OutBUS,
  output logic                     CONV_Busy_OutHigh,
  output logic                     CONV_Done_OutHigh
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SNAP = 3'd1,
    ST_MAC  = 3'd2,
    ST_OUT  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] COL_MSB = 3'(DATAWIDTH_BUS - 1);

  // Tap t = 3*i + j decomposed without a divider.
  function automatic logic [1:0] tap_row(input logic [3:0] t);
    case (t)
      4'd0, 4'd1, 4'd2: tap_row = 2'd0;
      4'd3, 4'd4, 4'd5: tap_row = 2'd1;
      default:          tap_row = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] tap_col(input logic [3:0] t);
    case (t)
      4'd0, 4'd3, 4'd6: tap_col = 2'd0;
      4'd1, 4'd4, 4'd7: tap_col = 2'd1;
      default:          tap_col = 2'd2;
    endcase
  endfunction

  function automatic logic [DATAWIDTH_BUS-1:0] relu_sat(input logic [ACC_WIDTH-1:0] a);
    if (a[ACC_WIDTH-1] || (a == {ACC_WIDTH{1'b0}})) begin
      relu_sat = {DATAWIDTH_BUS{1'b0}};
    end else if (|a[ACC_WIDTH-2:DATAWIDTH_BUS]) begin
      relu_sat = {DATAWIDTH_BUS{1'b1}};
    end else begin
      relu_sat = a[DATAWIDTH_BUS-1:0];
    end
  endfunction

  state_t                          state_q, state_d;
  logic [8:0][DATAWIDTH_BUS-1:0]   w_q, w_d;
  logic [7:0][DATAWIDTH_BUS-1:0]   snap_q, snap_d;
  logic [ACC_WIDTH-1:0]            acc_q, acc_d;
  logic [3:0]                      tap_q, tap_d;
  logic [2:0]                      r_q, r_d, c_q, c_d;
  logic                            valid_q, valid_d;
  logic [DATAWIDTH_BUS-1:0]        result_q, result_d;
  logic [5:0]                      index_q, index_d;
  logic                            busy_q, busy_d;
  logic                            done_q, done_d;

  logic [2:0]                      prow_s, pcol_s;
  logic                            pix_s;
  logic [DATAWIDTH_BUS-1:0]        wsel_s;
  logic [ACC_WIDTH-1:0]            addend_s, acc_sum_s;
  logic [5:0]                      pos_s;

  // Next-state, datapath and output computation.
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    snap_d   = snap_q;
    acc_d    = acc_q;
    tap_d    = tap_q;
    r_d      = r_q;
    c_d      = c_q;
    valid_d  = valid_q;
    result_d = result_q;
    index_d  = index_q;
    busy_d   = busy_q;
    done_d   = done_q;

    prow_s    = r_q + {1'b0, tap_row(tap_q)};
    pcol_s    = c_q + {1'b0, tap_col(tap_q)};
    pix_s     = snap_q[prow_s][COL_MSB - pcol_s];
    wsel_s    = w_q[tap_q];
    addend_s  = pix_s ? {{(ACC_WIDTH-DATAWIDTH_BUS){wsel_s[DATAWIDTH_BUS-1]}}, wsel_s}
                      : {ACC_WIDTH{1'b0}};
    acc_sum_s = acc_q + addend_s;
    pos_s     = 6'(r_q) * 6'd6 + 6'(c_q);

    if (!CONV_LoadWeight_InLow && (CONV_WeightAddress_InBUS <= 4'd8) && !busy_q) begin
      w_d[CONV_WeightAddress_InBUS] = CONV_New_WeightInBUS;
    end else begin
      w_d = w_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (CONV_Start_InHigh) begin
          state_d = ST_SNAP;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SNAP: begin
        snap_d  = {CONV_Row07_DataInBUS, CONV_Row06_DataInBUS, CONV_Row05_DataInBUS,
                   CONV_Row04_DataInBUS, CONV_Row03_DataInBUS, CONV_Row02_DataInBUS,
                   CONV_Row01_DataInBUS, CONV_Row00_DataInBUS};
        acc_d   = {ACC_WIDTH{1'b0}};
        tap_d   = 4'd0;
        r_d     = 3'd0;
        c_d     = 3'd0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        acc_d = acc_sum_s;
        if (tap_q == 4'd8) begin
          result_d = relu_sat(acc_sum_s);
          index_d  = pos_s;
          valid_d  = 1'b1;
          state_d  = ST_OUT;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      ST_OUT: begin
        if (CONV_Ready_InHigh) begin
          valid_d = 1'b0;
          if (index_q == 6'd35) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            if (c_q == 3'd5) begin
              c_d = 3'd0;
              r_d = r_q + 3'd1;
            end else begin
              c_d = c_q + 3'd1;
            end
            acc_d   = {ACC_WIDTH{1'b0}};
            tap_d   = 4'd0;
            state_d = ST_MAC;
          end
        end else begin
          state_d = ST_OUT;
        end
      end
      ST_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, kernel, snapshot and registered outputs.
  always_ff @(posedge CONV_CLOCK_50 or negedge CONV_RESET_InLow) begin
    if (!CONV_RESET_InLow) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      snap_q   <= '0;
      acc_q    <= {ACC_WIDTH{1'b0}};
      tap_q    <= 4'd0;
      r_q      <= 3'd0;
      c_q      <= 3'd0;
      valid_q  <= 1'b0;
      result_q <= {DATAWIDTH_BUS{1'b0}};
      index_q  <= 6'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      snap_q   <= snap_d;
      acc_q    <= acc_d;
      tap_q    <= tap_d;
      r_q      <= r_d;
      c_q      <= c_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      index_q  <= index_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign CONV_Valid_OutHigh      = valid_q;
  assign CONV_Result_DataOutBUS  = result_q;
  assign CONV_ResultIndex_OutBUS = index_q;
  assign CONV_Busy_OutHigh       = busy_q;
  assign CONV_Done_OutHigh       = done_q;

endmodule
